// File: rtl/aes_pkg.sv
// Shared constants and FSM encoding for the AES mode controller.
package aes_pkg;

    localparam int BW       = 128;
    localparam int MODE_ECB = 0;
    localparam int MODE_CBC = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KEY   = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

endpackage

// File: rtl/aes_cbc_ctrl.sv
// Mode controller in front of the AES_ENC core: loads key/IV, applies the
// CBC chaining XOR (or bypasses it in ECB), starts the core, waits for its
// result and hands the ciphertext back to the host with backpressure.
// One block is in flight at a time.
module aes_cbc_ctrl #(
    parameter int MODE_CBC = 1,
    parameter int BW       = 128
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [BW-1:0] Key_in,
    input  logic          Krdy_in,
    input  logic [BW-1:0] IV_in,
    input  logic          IVrdy_in,
    input  logic [BW-1:0] Pin,
    input  logic          Pvld,
    output logic          Prdy,
    output logic [BW-1:0] Cout,
    output logic          Cvld,
    input  logic          Crdy,
    output logic [BW-1:0] AES_Key,
    output logic          AES_Krdy,
    output logic [BW-1:0] AES_Din,
    output logic          AES_Drdy,
    output logic          AES_EN,
    input  logic [BW-1:0] AES_Dout,
    input  logic          AES_BSY,
    input  logic          AES_Dvld
);
    import aes_pkg::*;

    // ECB behaves as CBC with a chain value that is always zero.
    localparam logic CHAIN_EN = (MODE_CBC != MODE_ECB);

    state_t        state_q;
    logic [BW-1:0] chain_q;
    logic [BW-1:0] key_q;
    logic [BW-1:0] din_q;
    logic [BW-1:0] cout_q;
    logic          key_valid_q;
    logic          krdy_q;
    logic          drdy_q;
    logic          en_q;
    logic          cvld_q;

    logic [BW-1:0] din_d;
    logic          prdy_d;

    // Plaintext acceptance condition and the chaining XOR feeding the core.
    // Key/IV strobes block acceptance so a load never races a new block.
    always_comb begin
        prdy_d = (state_q == ST_IDLE) & key_valid_q & ~AES_BSY & ~Krdy_in & ~IVrdy_in;
        din_d  = CHAIN_EN ? (Pin ^ chain_q) : Pin;
    end

    // Controller FSM with registered core-side and host-side outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            chain_q     <= '0;
            key_q       <= '0;
            din_q       <= '0;
            cout_q      <= '0;
            key_valid_q <= 1'b0;
            krdy_q      <= 1'b0;
            drdy_q      <= 1'b0;
            en_q        <= 1'b0;
            cvld_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (IVrdy_in) begin
                        chain_q <= IV_in;
                    end
                    if (Krdy_in) begin
                        key_q   <= Key_in;
                        krdy_q  <= 1'b1;
                        state_q <= ST_KEY;
                    end else if (Pvld && prdy_d) begin
                        din_q   <= din_d;
                        drdy_q  <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_KEY: begin
                    // Key expansion time is covered by IDLE waiting on AES_BSY.
                    krdy_q      <= 1'b0;
                    key_valid_q <= 1'b1;
                    en_q        <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                ST_START: begin
                    drdy_q  <= 1'b0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Core latency is not counted; only Dvld ends the wait.
                    if (AES_Dvld) begin
                        cout_q  <= AES_Dout;
                        cvld_q  <= 1'b1;
                        if (CHAIN_EN) begin
                            chain_q <= AES_Dout;
                        end
                        state_q <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (Crdy) begin
                        cvld_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Prdy     = prdy_d;
    assign Cout     = cout_q;
    assign Cvld     = cvld_q;
    assign AES_Key  = key_q;
    assign AES_Krdy = krdy_q;
    assign AES_Din  = din_q;
    assign AES_Drdy = drdy_q;
    assign AES_EN   = en_q;

endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// Scoreboard bench for aes_cbc_ctrl: one ECB and one CBC instance driven
// against a behavioural stand-in for the AES_ENC core that knows the
// FIPS-197 / SP800-38A vectors used here.
`timescale 1ns/1ps
module tb_aes_cbc_ctrl;

    localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1C1 = 128'h69d5c2eb2e2e624750541d3bbc692ba5;
    localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P2   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] X2   = 128'h6bc0bce12a459991e134741a7f9e1925;
    localparam logic [127:0] C2   = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] BAD  = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;

    logic CLK = 1'b0;
    logic RST;

    logic [127:0] key_in [2];
    logic [127:0] iv_in [2];
    logic [127:0] pin [2];
    logic [127:0] cout [2];
    logic [127:0] aes_key [2];
    logic [127:0] aes_din [2];
    logic [127:0] aes_dout [2];
    logic [1:0]   krdy_in, ivrdy_in, pvld, prdy, cvld, crdy;
    logic [1:0]   aes_krdy, aes_drdy, aes_en, aes_bsy, aes_dvld;

    // core stand-in state
    logic [127:0] core_key [2];
    logic [127:0] core_din [2];
    logic [127:0] core_dout [2];
    int           bsy_cnt [2];
    logic [1:0]   pend, core_dvld, spur;

    logic [127:0] q_din [2][$];
    logic [127:0] q_cout [2][$];

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    aes_cbc_ctrl #(.MODE_CBC(0), .BW(128)) u_ecb (
        .CLK(CLK), .RST(RST),
        .Key_in(key_in[0]), .Krdy_in(krdy_in[0]),
        .IV_in(iv_in[0]), .IVrdy_in(ivrdy_in[0]),
        .Pin(pin[0]), .Pvld(pvld[0]), .Prdy(prdy[0]),
        .Cout(cout[0]), .Cvld(cvld[0]), .Crdy(crdy[0]),
        .AES_Key(aes_key[0]), .AES_Krdy(aes_krdy[0]),
        .AES_Din(aes_din[0]), .AES_Drdy(aes_drdy[0]), .AES_EN(aes_en[0]),
        .AES_Dout(aes_dout[0]), .AES_BSY(aes_bsy[0]), .AES_Dvld(aes_dvld[0])
    );

    aes_cbc_ctrl #(.MODE_CBC(1), .BW(128)) u_cbc (
        .CLK(CLK), .RST(RST),
        .Key_in(key_in[1]), .Krdy_in(krdy_in[1]),
        .IV_in(iv_in[1]), .IVrdy_in(ivrdy_in[1]),
        .Pin(pin[1]), .Pvld(pvld[1]), .Prdy(prdy[1]),
        .Cout(cout[1]), .Cvld(cvld[1]), .Crdy(crdy[1]),
        .AES_Key(aes_key[1]), .AES_Krdy(aes_krdy[1]),
        .AES_Din(aes_din[1]), .AES_Drdy(aes_drdy[1]), .AES_EN(aes_en[1]),
        .AES_Dout(aes_dout[1]), .AES_BSY(aes_bsy[1]), .AES_Dvld(aes_dvld[1])
    );

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] d);
        if (k == K1 && d == P1) return C1;
        if (k == K2 && d == X2) return C2;
        return ~d;
    endfunction

    assign aes_bsy[0]  = (bsy_cnt[0] != 0);
    assign aes_bsy[1]  = (bsy_cnt[1] != 0);
    assign aes_dvld    = core_dvld | spur;
    assign aes_dout[0] = spur[0] ? BAD : core_dout[0];
    assign aes_dout[1] = spur[1] ? BAD : core_dout[1];

    // AES core stand-in: 10 busy cycles after a key load, 11 after a start,
    // with a one-cycle Dvld pulse at the end of a data operation.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 2; i++) begin
                bsy_cnt[i]   <= 0;
                core_key[i]  <= '0;
                core_din[i]  <= '0;
                core_dout[i] <= '0;
            end
            pend      <= '0;
            core_dvld <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                core_dvld[i] <= 1'b0;
                if (aes_krdy[i]) begin
                    core_key[i] <= aes_key[i];
                    bsy_cnt[i]  <= 10;
                end else if (aes_drdy[i]) begin
                    core_din[i] <= aes_din[i];
                    bsy_cnt[i]  <= 11;
                    pend[i]     <= 1'b1;
                end else if (bsy_cnt[i] != 0) begin
                    bsy_cnt[i] <= bsy_cnt[i] - 1;
                    if (bsy_cnt[i] == 1 && pend[i]) begin
                        core_dvld[i] <= 1'b1;
                        core_dout[i] <= aes_ref(core_key[i], core_din[i]);
                        pend[i]      <= 1'b0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Monitor: pops the scoreboard on every core start and every host transfer.
    logic [1:0] prev_drdy = '0;
    logic [1:0] prev_cdvld = '0;
    always @(negedge CLK) begin
        logic [127:0] e;
        for (int i = 0; i < 2; i++) begin
            if (!RST) begin
                if (aes_drdy[i]) begin
                    chk("drdy_width", {127'd0, prev_drdy[i]}, 128'd0);
                    if (q_din[i].size() == 0) begin
                        fail_now($sformatf("unexpected_drdy inst %0d din %h", i, aes_din[i]));
                    end else begin
                        e = q_din[i].pop_front();
                        chk($sformatf("aes_din inst %0d", i), aes_din[i], e);
                    end
                end
                if (prev_cdvld[i]) begin
                    chk($sformatf("cvld_latency inst %0d", i), {127'd0, cvld[i]}, 128'd1);
                end
                if (cvld[i] && crdy[i]) begin
                    if (q_cout[i].size() == 0) begin
                        fail_now($sformatf("unexpected_cout inst %0d cout %h", i, cout[i]));
                    end else begin
                        e = q_cout[i].pop_front();
                        chk($sformatf("cout inst %0d", i), cout[i], e);
                    end
                end
                prev_drdy[i]  = aes_drdy[i];
                prev_cdvld[i] = core_dvld[i];
            end else begin
                prev_drdy[i]  = 1'b0;
                prev_cdvld[i] = 1'b0;
            end
        end
    end

    task automatic chk_zero(input int i, input string tag);
        chk({tag, "_prdy"}, {127'd0, prdy[i]}, 128'd0);
        chk({tag, "_cvld"}, {127'd0, cvld[i]}, 128'd0);
        chk({tag, "_cout"}, cout[i], 128'd0);
        chk({tag, "_key"}, aes_key[i], 128'd0);
        chk({tag, "_krdy"}, {127'd0, aes_krdy[i]}, 128'd0);
        chk({tag, "_din"}, aes_din[i], 128'd0);
        chk({tag, "_drdy"}, {127'd0, aes_drdy[i]}, 128'd0);
        chk({tag, "_en"}, {127'd0, aes_en[i]}, 128'd0);
    endtask

    task automatic load_key(input int i, input logic [127:0] k, input logic [127:0] iv);
        @(posedge CLK); #1;
        key_in[i] = k; iv_in[i] = iv; krdy_in[i] = 1'b1; ivrdy_in[i] = 1'b1;
        @(posedge CLK); #1;
        krdy_in[i] = 1'b0; ivrdy_in[i] = 1'b0;
        @(negedge CLK);
        chk("krdy_pulse", {127'd0, aes_krdy[i]}, 128'd1);
        chk("aes_key", aes_key[i], k);
        @(negedge CLK);
        chk("krdy_end", {127'd0, aes_krdy[i]}, 128'd0);
        chk("prdy_during_keyexp", {127'd0, prdy[i]}, 128'd0);
        chk("aes_en", {127'd0, aes_en[i]}, 128'd1);
    endtask

    task automatic send(input int i, input logic [127:0] p, input logic [127:0] exp_din,
                        input logic [127:0] exp_c, input bit expect_out);
        int n;
        q_din[i].push_back(exp_din);
        if (expect_out) q_cout[i].push_back(exp_c);
        @(posedge CLK); #1;
        pin[i] = p; pvld[i] = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!prdy[i] && n < 300);
        if (!prdy[i]) begin
            fail_now($sformatf("prdy_timeout inst %0d", i));
            pvld[i] = 1'b0;
            return;
        end
        @(posedge CLK); #1;
        pvld[i] = 1'b0; pin[i] = '0;
        @(negedge CLK);
        chk("drdy_latency", {127'd0, aes_drdy[i]}, 128'd1);
        @(negedge CLK);
        chk("drdy_single", {127'd0, aes_drdy[i]}, 128'd0);
    endtask

    task automatic wait_done(input int i);
        int n;
        n = 0;
        while ((q_cout[i].size() != 0 || cvld[i]) && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (q_cout[i].size() != 0 || cvld[i]) fail_now($sformatf("done_timeout inst %0d", i));
    endtask

    task automatic wait_cvld(input int i);
        int n;
        n = 0;
        while (!cvld[i] && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk("cvld_seen", {127'd0, cvld[i]}, 128'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            key_in[i] = '0; iv_in[i] = '0; pin[i] = '0;
        end
        krdy_in = '0; ivrdy_in = '0; pvld = '0; crdy = 2'b11; spur = '0;
        repeat (2) @(negedge CLK);
        chk_zero(0, "rst_ecb");
        chk_zero(1, "rst_cbc");
        @(posedge CLK); #1;
        RST = 1'b0;

        // No key loaded: a pending plaintext must not be accepted.
        pvld[1] = 1'b1; pin[1] = P1;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk("prdy_nokey", {127'd0, prdy[1]}, 128'd0);
        end
        @(posedge CLK); #1;
        pvld[1] = 1'b0;

        // ECB with a nonzero IV loaded: the IV must not reach the core.
        load_key(0, K1, IV2);
        crdy[0] = 1'b0;
        send(0, P1, P1, C1, 1'b1);
        wait_cvld(0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("ecb_cvld_hold", {127'd0, cvld[0]}, 128'd1);
            chk("ecb_cout_hold", cout[0], C1);
        end
        @(posedge CLK); #1;
        crdy[0] = 1'b1;
        wait_done(0);

        // CBC, IV = 0, two chained blocks.
        load_key(1, K1, 128'd0);
        send(1, P1, P1, C1, 1'b1);
        wait_done(1);
        send(1, P1C1, P1, C1, 1'b1);
        wait_done(1);

        // CBC SP800-38A first block.
        load_key(1, K2, IV2);
        send(1, P2, X2, C2, 1'b1);
        wait_done(1);

        // Backpressure with a spurious Dvld pulse while holding the result.
        load_key(1, K2, IV2);
        crdy[1] = 1'b0;
        send(1, P2, X2, C2, 1'b1);
        wait_cvld(1);
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            chk("bp_cout", cout[1], C2);
            chk("bp_cvld", {127'd0, cvld[1]}, 128'd1);
            chk("bp_prdy", {127'd0, prdy[1]}, 128'd0);
            spur[1] = (k == 5);
        end
        spur[1] = 1'b0;
        @(posedge CLK); #1;
        crdy[1] = 1'b1;
        wait_done(1);

        // Reset while the core is working: everything clears at once.
        load_key(1, K1, 128'd0);
        send(1, P1, P1, C1, 1'b0);
        repeat (3) @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk_zero(1, "rst_wait");
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        pvld[1] = 1'b1; pin[1] = P1;
        for (int k = 0; k < 30; k++) begin
            @(negedge CLK);
            chk("prdy_after_rst", {127'd0, prdy[1]}, 128'd0);
            chk("cvld_after_rst", {127'd0, cvld[1]}, 128'd0);
        end
        @(posedge CLK); #1;
        pvld[1] = 1'b0;
        @(negedge CLK);

        chk("leftover_din0", q_din[0].size(), 128'd0);
        chk("leftover_din1", q_din[1].size(), 128'd0);
        chk("leftover_cout0", q_cout[0].size(), 128'd0);
        chk("leftover_cout1", q_cout[1].size(), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_cbc_ctrl.md
Name: aes_cbc_ctrl

Overview:
- Upstream mode controller that feeds the AES_ENC core and consumes its result.
- Accepts a key, an IV and a stream of 128-bit plaintext blocks from the host over a valid/ready handshake.
- In CBC mode it XORs each plaintext block with the chaining value and drives the core's Key/Krdy/Din/Drdy/EN inputs. It waits for Dvld, then returns the ciphertext to the host over a valid/ready handshake with backpressure.
- In ECB mode the chaining XOR is bypassed.

Parameters:
- MODE_CBC, 1, 1 = CBC chaining; 0 = ECB (chain value ignored, treated as zero).
- BW, 128, block and key width; fixed at 128 and not otherwise supported.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- Key_in  in  BW  host key.
- Krdy_in  in  1  host key-load strobe.
- IV_in  in  BW  host initialisation vector.
- IVrdy_in  in  1  host IV-load strobe.
- Pin  in  BW  plaintext block.
- Pvld  in  1  plaintext valid.
- Prdy  out  1  controller ready for plaintext.
- Cout  out  BW  ciphertext block.
- Cvld  out  1  ciphertext valid.
- Crdy  in  1  host ready for ciphertext.
- AES_Key  out  BW  key to core.
- AES_Krdy  out  1  key-load pulse to core.
- AES_Din  out  BW  data to core.
- AES_Drdy  out  1  data-start pulse to core.
- AES_EN  out  1  core enable.
- AES_Dout  in  BW  core result.
- AES_BSY  in  1  core busy.
- AES_Dvld  in  1  core result-valid pulse.

Behaviour:
- Reset: applied asynchronously via RST. All outputs reset to 0:
  - Prdy=0, Cvld=0, Cout=0, AES_Key=0, AES_Krdy=0, AES_Din=0, AES_Drdy=0, AES_EN=0.
  - Internal: state=IDLE, chain=0, key_valid=0.
- FSM states: IDLE, KEY, START, WAIT, OUT. The state encoding is in the package.
- IDLE:
  - AES_EN=1 once key_valid=1.
  - If Krdy_in=1: AES_Key<=Key_in, AES_Krdy<=1, go to KEY. This has priority over Pvld.
  - If IVrdy_in=1: chain<=IV_in. The IV is accepted in IDLE only; it may coincide with Krdy_in, and both are taken.
  - Prdy = (state==IDLE) & key_valid & ~AES_BSY & ~Krdy_in & ~IVrdy_in. Prdy is combinational.
  - If Pvld&Prdy: AES_Din<=Pin^chain (or Pin in ECB), AES_Drdy<=1, go to START.
- KEY:
  - AES_Krdy returns to 0 after exactly one cycle; key_valid<=1.
  - Go to IDLE. IDLE then waits for AES_BSY=0 before raising Prdy, which covers the key-expansion time.
- START: AES_Drdy returns to 0 after exactly one cycle; go to WAIT.
- WAIT:
  - Hold until AES_Dvld=1.
  - On that edge: Cout<=AES_Dout, Cvld<=1, and chain<=AES_Dout in CBC mode; go to OUT.
  - The design does not count core latency; it depends only on Dvld.
- OUT:
  - Cvld held with Cout stable until Crdy=1.
  - On Cvld&Crdy: Cvld<=0, go to IDLE. The next Prdy is available the following cycle.
- Latency: Pvld&Prdy at edge t, then AES_Drdy=1 in cycle t+1. Core Dvld at edge d, then Cvld=1 in cycle d+1.
- Throughput: one block in flight; no overlap.
- AES_Dvld outside WAIT is ignored: no state or output change.
- Krdy_in outside IDLE is ignored (the host must retry). A key reload keeps chain unchanged.
- IVrdy_in outside IDLE is ignored.
- Pvld is held by the host until Prdy; Pin is sampled only on the handshake edge.
- RST asserted in any state returns to reset values at once. Any in-progress block is discarded and key_valid=0, so the host must reload the key and IV.
- Chain update uses the ciphertext only; no arithmetic beyond a 128-bit XOR.

Decomposition:
- Shared package aes_pkg holds:
  - BW=128 constant.
  - FSM state encoding (3-bit: IDLE, KEY, START, WAIT, OUT).
  - Mode constants MODE_ECB=0, MODE_CBC=1.
- No sub-module is needed; this is a single flat module.
- The top level instantiates aes_cbc_ctrl alongside AES_ENC. Core RSTn is driven by ~RST.

Test Plan:
- ECB, key 000102030405060708090a0b0c0d0e0f, Pin 00112233445566778899aabbccddeeff -> Cout 69c4e0d86a7b0430d8cdb78070b4c55a; Cvld high until Crdy.
- CBC, IV=0, same key and Pin -> Cout 69c4e0d8...c55a. Second block Pin = 00112233...ff ^ 69c4e0d8...c55a -> Cout 69c4e0d86a7b0430d8cdb78070b4c55a again.
- CBC, key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102030405060708090a0b0c0d0e0f, Pin 6bc1bee22e409f96e93d7e117393172a -> Cout 7649abac8119b246cee98e9b12e9197d.
- Backpressure: Crdy held low for 20 cycles after Cvld -> Cout stable, Prdy=0 throughout; a spurious AES_Dvld pulse injected changes nothing.
- Handshake timing: Pvld asserted while key_valid=0 or AES_BSY=1 -> Prdy=0, no AES_Drdy. Once ready, exactly one single-cycle AES_Drdy pulse one cycle after the handshake.
- RST asserted during WAIT -> all outputs 0 immediately. A subsequent Pvld without a key reload is never accepted (Prdy=0).
